// File: rtl/uart_cal_ctrl.sv
// =====================================================================
// Module   : uart_cal_ctrl
// Brief    : Parses 4-byte UART frames (HDR, A, OP, B) into calculator
//            commands; optional inter-byte timeout via UART_CAL_CTRL_TIMEOUT_EN.
// Revision : 1.0
// =====================================================================
`default_nettype none

module uart_cal_ctrl #(
    parameter logic [15:0] TIMEOUT = 16'h0FFF,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_start,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [1:0] opcode,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_OP = 3'd2,
        S_GET_B  = 3'd3,
        S_ISSUE  = 3'd4
    } state_t;

    localparam logic [1:0] c_ERR_OPCODE  = 2'd1;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'd2;
    localparam logic [7:0] c_CH_ADD      = 8'h2B;
    localparam logic [7:0] c_CH_SUB      = 8'h2D;
    localparam logic [7:0] c_CH_MUL      = 8'h2A;
    localparam logic [7:0] c_CH_DIV      = 8'h2F;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_op_a;
    logic [7:0] r_op_b;
    logic [1:0] r_opcode;
    logic       r_err;
    logic [1:0] r_err_code;

    logic       w_lat_a;
    logic       w_lat_op;
    logic       w_lat_b;
    logic       w_bad_op;
    logic       w_op_ok;
    logic [1:0] w_op_dec;
    logic       w_timeout;
    logic       w_issue;

`ifdef UART_CAL_CTRL_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        w_in_get;

    assign w_in_get  = (r_state == S_GET_A) || (r_state == S_GET_OP) || (r_state == S_GET_B);
    // A byte landing on the limit cycle wins over the timeout.
    assign w_timeout = w_in_get && !rx_valid && (r_to_cnt == TIMEOUT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_to_cnt <= 16'd0;
        end else if (!w_in_get || rx_valid || w_timeout) begin
            r_to_cnt <= 16'd0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_op_ok  = 1'b1;
        w_op_dec = 2'd0;
        case (rx_data)
            c_CH_ADD: w_op_dec = 2'd0;
            c_CH_SUB: w_op_dec = 2'd1;
            c_CH_MUL: w_op_dec = 2'd2;
            c_CH_DIV: w_op_dec = 2'd3;
            default:  w_op_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_a     = 1'b0;
        w_lat_op    = 1'b0;
        w_lat_b     = 1'b0;
        w_bad_op    = 1'b0;
        case (r_state)
            S_HUNT: begin
                if (rx_valid && (rx_data == HDR)) begin
                    w_state_nxt = S_GET_A;
                end
            end
            S_GET_A: begin
                if (rx_valid) begin
                    w_lat_a     = 1'b1;
                    w_state_nxt = S_GET_OP;
                end else if (w_timeout) begin
                    w_state_nxt = S_HUNT;
                end
            end
            S_GET_OP: begin
                if (rx_valid) begin
                    if (w_op_ok) begin
                        w_lat_op    = 1'b1;
                        w_state_nxt = S_GET_B;
                    end else begin
                        w_bad_op    = 1'b1;
                        w_state_nxt = S_HUNT;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_HUNT;
                end
            end
            S_GET_B: begin
                if (rx_valid) begin
                    w_lat_b     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (w_timeout) begin
                    w_state_nxt = S_HUNT;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    w_state_nxt = S_HUNT;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_op_a     <= 8'd0;
            r_op_b     <= 8'd0;
            r_opcode   <= 2'd0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            if (w_lat_a) begin
                r_op_a <= rx_data;
            end
            if (w_lat_op) begin
                r_opcode <= w_op_dec;
            end
            if (w_lat_b) begin
                r_op_b <= rx_data;
            end
            r_err <= w_bad_op | w_timeout;
            if (w_bad_op) begin
                r_err_code <= c_ERR_OPCODE;
            end else if (w_timeout) begin
                r_err_code <= c_ERR_TIMEOUT;
            end
        end
    end

    assign w_issue   = (r_state == S_ISSUE);
    assign cmd_valid = w_issue;
    assign rx_start  = !w_issue;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign opcode    = r_opcode;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_uart_cal_ctrl.sv
// =====================================================================
// Module   : tb_uart_cal_ctrl
// Brief    : Self-checking bench for uart_cal_ctrl (frame table + scoreboard).
// Revision : 1.0
// =====================================================================
`default_nettype none

module tb_uart_cal_ctrl;

    logic       clk       = 1'b0;
    logic       n_rst     = 1'b0;
    logic       rx_valid  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       cmd_ready = 1'b0;
    logic       rx_start;
    logic       cmd_valid;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] opcode;
    logic       err;
    logic [1:0] err_code;

    uart_cal_ctrl #(
        .TIMEOUT(16'h0010),
        .HDR    (8'hA5)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_start (rx_start),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .opcode   (opcode),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] bytes;     // first byte in [47:40]
        int          n;
        int          delay;     // cycles cmd_ready is held low while cmd_valid
        logic        inject;    // pulse rx_valid during the wait
        logic        exp_cmd;
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
        logic [1:0]  exp_op;    // for error frames: opcode that must be retained
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        int         cycles;
    } exp_cmd_t;

    int         checks = 0;
    int         errors = 0;
    exp_cmd_t   cmd_q[$];
    logic [1:0] err_q[$];
    vec_t       vecs[7];

    logic       prev_cv  = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] snap_a;
    logic [7:0] snap_b;
    logic [1:0] snap_op;
    int         cv_cnt = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] b, input int n, input int dly, input logic inj,
                                input logic ec, input logic [7:0] a, input logic [7:0] bb,
                                input logic [1:0] op, input logic ee, input logic [1:0] code);
        vec_t v;
        v.bytes = b; v.n = n; v.delay = dly; v.inject = inj; v.exp_cmd = ec;
        v.exp_a = a; v.exp_b = bb; v.exp_op = op; v.exp_err = ee; v.exp_code = code;
        return v;
    endfunction

    task automatic monitor();
        exp_cmd_t e;
        if (cmd_valid) begin
            if (!prev_cv) begin
                snap_a = op_a; snap_b = op_b; snap_op = opcode; cv_cnt = 1;
            end else begin
                cv_cnt++;
                check_eq("cmd_stable", {op_a, op_b, 6'd0, opcode}, {snap_a, snap_b, 6'd0, snap_op});
            end
            check_eq("rx_start_issue", rx_start, 1'b0);
        end else begin
            check_eq("rx_start_idle", rx_start, 1'b1);
        end
        if (prev_cv && cmd_ready) begin
            check_eq("cmd_expected", cmd_q.size() > 0, 1'b1);
            if (cmd_q.size() > 0) begin
                e = cmd_q.pop_front();
                check_eq("cmd_op_a", snap_a, e.a);
                check_eq("cmd_op_b", snap_b, e.b);
                check_eq("cmd_opcode", snap_op, e.op);
                check_eq("cmd_valid_cycles", cv_cnt, e.cycles);
            end
            check_eq("cmd_valid_drop", cmd_valid, 1'b0);
        end
        if (err) begin
            check_eq("err_single_cycle", prev_err, 1'b0);
            check_eq("err_expected", err_q.size() > 0, 1'b1);
            if (err_q.size() > 0) begin
                check_eq("err_code", err_code, err_q.pop_front());
            end
        end
        prev_cv  = cmd_valid;
        prev_err = err;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_cmd_valid"}, cmd_valid, 1'b0);
        check_eq({tag, "_rx_start"}, rx_start, 1'b1);
        check_eq({tag, "_op_a"}, op_a, 8'h00);
        check_eq({tag, "_op_b"}, op_b, 8'h00);
        check_eq({tag, "_opcode"}, opcode, 2'd0);
        check_eq({tag, "_err"}, err, 1'b0);
        check_eq({tag, "_err_code"}, err_code, 2'd0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_cmd_t e;
        if (v.exp_cmd) begin
            e.a = v.exp_a; e.b = v.exp_b; e.op = v.exp_op; e.cycles = v.delay + 1;
            cmd_q.push_back(e);
        end
        if (v.exp_err) begin
            err_q.push_back(v.exp_code);
        end
        cmd_ready = (v.delay == 0);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.bytes[47-8*i -: 8]);
        end
        if (v.exp_cmd) begin
            check_eq("cmd_latency", cmd_valid, 1'b1);
            for (int i = 0; i < v.delay; i++) begin
                cmd_ready = 1'b0;
                if (v.inject && (i % 2 == 0)) begin
                    rx_valid = 1'b1;
                    rx_data  = 8'hA5;
                end
                tick();
                rx_valid = 1'b0;
            end
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            check_eq("cmd_consumed", cmd_q.size(), 0);
        end else begin
            cmd_ready = 1'b0;
            check_eq("no_cmd", cmd_valid, 1'b0);
        end
        if (v.exp_err) begin
            check_eq("err_timing", err_q.size(), 0);
            check_eq("opcode_retained", opcode, v.exp_op);
            tick();
            check_eq("err_code_hold", err_code, v.exp_code);
        end
    endtask

    initial begin
        exp_cmd_t e;
        vecs[0] = mk({8'hA5, 8'h12, 8'h2B, 8'h34, 16'h0}, 4, 0, 1'b0, 1'b1, 8'h12, 8'h34, 2'd0, 1'b0, 2'd0);
        vecs[1] = mk({8'hA5, 8'h05, 8'h2F, 8'h02, 16'h0}, 4, 10, 1'b1, 1'b1, 8'h05, 8'h02, 2'd3, 1'b0, 2'd0);
        vecs[2] = mk({8'h00, 8'hFF, 8'hA5, 8'h07, 8'h2A, 8'h03}, 6, 0, 1'b0, 1'b1, 8'h07, 8'h03, 2'd2, 1'b0, 2'd0);
        vecs[3] = mk({8'hA5, 8'h01, 8'h3D, 24'h0}, 3, 0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd2, 1'b1, 2'd1);
        vecs[4] = mk({8'hA5, 8'h01, 8'h2D, 8'h01, 16'h0}, 4, 0, 1'b0, 1'b1, 8'h01, 8'h01, 2'd1, 1'b0, 2'd0);
        vecs[5] = mk({8'hA5, 8'hFF, 8'h2A, 8'hFF, 16'h0}, 4, 2, 1'b0, 1'b1, 8'hFF, 8'hFF, 2'd2, 1'b0, 2'd0);
        vecs[6] = mk({8'hA5, 8'hA5, 8'h2D, 8'hA5, 16'h0}, 4, 0, 1'b0, 1'b1, 8'hA5, 8'hA5, 2'd1, 1'b0, 2'd0);

        tick();
        tick();
        check_reset_vals("in_reset");
        n_rst = 1'b1;
        tick();
        check_reset_vals("after_reset");

        // Frames are sent back to back: each header lands in the first HUNT cycle.
        for (int k = 0; k < 7; k++) begin
            run_vec(vecs[k]);
        end

`ifdef UART_CAL_CTRL_TIMEOUT_EN
        err_q.push_back(2'd2);
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int i = 0; i < 16; i++) tick();
        check_eq("timeout_not_early", err_q.size(), 1);
        tick();
        check_eq("timeout_fired", err_q.size(), 0);
        check_eq("timeout_no_cmd", cmd_valid, 1'b0);

        e.a = 8'h04; e.b = 8'h06; e.op = 2'd2; e.cycles = 1;
        cmd_q.push_back(e);
        send_byte(8'hA5);
        send_byte(8'h04);
        for (int i = 0; i < 16; i++) tick();
        send_byte(8'h2A);
        cmd_ready = 1'b1;
        send_byte(8'h06);
        check_eq("limit_cmd_valid", cmd_valid, 1'b1);
        tick();
        cmd_ready = 1'b0;
        check_eq("limit_cmd_consumed", cmd_q.size(), 0);
`else
        e.a = 8'h09; e.b = 8'h03; e.op = 2'd3; e.cycles = 1;
        cmd_q.push_back(e);
        send_byte(8'hA5);
        send_byte(8'h09);
        for (int i = 0; i < 40; i++) tick();
        send_byte(8'h2F);
        cmd_ready = 1'b1;
        send_byte(8'h03);
        check_eq("idle_cmd_valid", cmd_valid, 1'b1);
        tick();
        cmd_ready = 1'b0;
        check_eq("idle_cmd_consumed", cmd_q.size(), 0);
`endif

        // Reset in the middle of a frame, before the B byte.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h2B);
        n_rst = 1'b0;
        #1;
        check_reset_vals("mid_frame_reset");
        tick();
        tick();
        n_rst = 1'b1;
        tick();
        check_reset_vals("post_abort");
        run_vec(vecs[0]);

        for (int i = 0; i < 4; i++) tick();
        check_eq("cmd_q_empty", cmd_q.size(), 0);
        check_eq("err_q_empty", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_cal_ctrl.md
UART_CAL_CTRL -- requirements
Module: uart_cal_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16'h0FFF, idle-cycle limit between bytes inside a frame.
REQ-002 Parameter HDR, default 8'hA5, frame header byte.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 rx_valid  input  1  one-cycle pulse from UART receiver, byte on rx_data.
REQ-006 rx_data  input  8  received byte, sampled only when rx_valid=1.
REQ-007 rx_start  output  1  enable to UART receiver; 1 = receiver may capture bytes.
REQ-008 cmd_valid  output  1  calculator command available.
REQ-009 cmd_ready  input  1  calculator accepts command when cmd_valid&&cmd_ready.
REQ-010 op_a  output  8  operand A, stable while cmd_valid=1.
REQ-011 op_b  output  8  operand B, stable while cmd_valid=1.
REQ-012 opcode  output  2  0=add, 1=sub, 2=mul, 3=div.
REQ-013 err  output  1  one-cycle error pulse.
REQ-014 err_code  output  2  1=bad opcode, 2=timeout; holds last code until next err.

Function
REQ-015 Frame = 4 bytes in order: HDR, A, OP, B; states HUNT, GET_A, GET_OP, GET_B, ISSUE.
REQ-016 HUNT: rx_valid with rx_data==HDR -> GET_A; any other byte discarded silently, stay HUNT.
REQ-017 GET_A: rx_valid -> latch op_a, go GET_OP.
REQ-018 GET_OP: rx_valid with 0x2B/0x2D/0x2A/0x2F -> opcode 0/1/2/3, go GET_B.
REQ-019 GET_OP: any other byte -> err=1 next cycle, err_code=1, go HUNT, op_a/opcode unchanged.
REQ-020 GET_B: rx_valid -> latch op_b, go ISSUE; cmd_valid=1 from the first ISSUE cycle (1-cycle latency after last byte's rx_valid).
REQ-021 ISSUE: cmd_valid held 1 with op_a/op_b/opcode frozen until cmd_ready=1 sampled; on that edge go HUNT, cmd_valid=0 next cycle.
REQ-022 cmd_ready while cmd_valid=0 ignored.
REQ-023 rx_start=1 in HUNT, GET_A, GET_OP, GET_B; 0 in ISSUE (backpressure to receiver).
REQ-024 rx_valid during ISSUE ignored; byte dropped, no error.
REQ-025 Back-to-back frames: HDR byte arriving in first HUNT cycle after ISSUE accepted normally.

Reset
REQ-026 n_rst low: state=HUNT, rx_start=1 after release, cmd_valid=0, op_a=op_b=0, opcode=0, err=0, err_code=0, timeout counter=0.
REQ-027 Reset mid-frame or mid-ISSUE aborts immediately; partial frame discarded, no err.

Configuration
REQ-028 Macro UART_CAL_CTRL_TIMEOUT_EN compiles in inter-byte timeout.
REQ-029 Defined: counter clears on each rx_valid and on entry to GET_A, increments each cycle in GET_A/GET_OP/GET_B; when counter==TIMEOUT and rx_valid=0 -> err pulse, err_code=2, go HUNT.
REQ-030 Defined: rx_valid in same cycle counter reaches TIMEOUT -> byte processed, no timeout.
REQ-031 Defined: counter held 0 in HUNT and ISSUE; no timeout in those states.
REQ-032 Undefined: no counter logic; GET_* states wait indefinitely; err_code never 2.

Verification
REQ-033 Frame A5,12,2B,34, cmd_ready=1 -> cmd_valid 1 cycle, op_a=0x12, op_b=0x34, opcode=0, rx_start=0 that cycle.
REQ-034 Frame A5,05,2F,02, cmd_ready held 0 for 10 cycles then 1 -> cmd_valid high 11 cycles, outputs stable, extra rx_valid pulses during wait ignored.
REQ-035 Bytes 00,FF,A5,07,2A,03 -> first two discarded, command op_a=7, opcode=2, op_b=3, no err.
REQ-036 Frame A5,01,3D -> err pulse 1 cycle, err_code=1, state HUNT; following A5,01,2D,01 -> opcode=1.
REQ-037 With UART_CAL_CTRL_TIMEOUT_EN, TIMEOUT=16'h0010: A5,01 then silence -> err with err_code=2 at 17th idle cycle; byte exactly at limit -> no err.
REQ-038 Assert n_rst after A5,01,2B -> all outputs at reset values; next full frame decoded correctly.
